// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl_if
//  Brief    : Command/result bundle between a requester and serial_add_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             abort;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, abort, sub, a, b, c_in,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, abort, sub, a, b, c_in,
        output busy, done, sum, c_out, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl
//  Brief    : Bit-serial add/subtract, one full-adder cell, LSB first.
//  Revision : 1.0  initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int                CNT_W      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  C_LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_sub;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_ovf;

    logic             w_accept;
    logic             w_abort;
    logic             w_step;
    logic             w_last;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_sum_bit;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_busy;
    logic             w_done;

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
    assign w_abort  = (r_state == S_RUN) && bus.abort;
    assign w_step   = (r_state == S_RUN) && !bus.abort;
    assign w_last   = w_step && (r_cnt == C_LAST_BIT);

    // Single full-adder cell; subtraction is a + ~b + 1 with the +1 preloaded as carry.
    assign w_a_bit     = r_a_sh[0];
    assign w_b_bit     = r_b_sh[0] ^ r_sub;
    assign w_sum_bit   = w_a_bit ^ w_b_bit ^ r_carry;
    assign w_carry_nxt = (w_a_bit & w_b_bit) | (r_carry & (w_a_bit ^ w_b_bit));
    assign w_res_nxt   = {w_sum_bit, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = bus.start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Published result only moves on the final bit step, so it holds through RUN and aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_sub   <= bus.sub;
            r_carry <= bus.sub ? 1'b1 : bus.c_in;
            r_cnt   <= '0;
            r_res   <= '0;
        end else if (w_step) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_carry <= w_carry_nxt;
            r_cnt   <= r_cnt + 1'b1;
            r_res   <= w_res_nxt;
            if (w_last) begin
                r_sum   <= w_res_nxt;
                r_c_out <= w_carry_nxt;
                r_ovf   <= r_carry ^ w_carry_nxt;
            end
        end
    end

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.sum   = r_sum;
    assign bus.c_out = r_c_out;
    assign bus.ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_ctrl
//  Brief    : Directed and randomized bench for serial_add_ctrl (WIDTH=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W-1:0] exp_sum;
    logic         exp_c_out;
    logic         exp_ovf;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic cin, output logic [W-1:0] r, output logic c,
                                  output logic o);
        int ua = int'(av);
        int ub = int'(bv);
        int sa = int'($signed(av));
        int sb = int'($signed(bv));
        int full;
        int sres;
        if (!s) begin
            full = ua + ub + int'(cin);
            r    = W'(full);
            c    = full[W];
            sres = sa + sb + int'(cin);
        end else begin
            r    = av - bv;
            c    = (ua >= ub);
            sres = sa - sb;
        end
        o = (sres > 32767) || (sres < -32768);
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_sum"},   64'(bus.sum),   64'(exp_sum));
        chk({tag, "_c_out"}, 64'(bus.c_out), 64'(exp_c_out));
        chk({tag, "_ovf"},   64'(bus.ovf),   64'(exp_ovf));
    endtask

    // kind: 0 plain, 1 start pulse injected in RUN, 2 abort (with start) injected in RUN.
    // Returns positioned in the done cycle (kind 0/1) or in IDLE (kind 2).
    task automatic run_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cin, input int kind, input int at);
        int           n;
        int           dones;
        logic [W-1:0] ms;
        logic         mc;
        logic         mo;
        model(s, av, bv, cin, ms, mc, mo);
        bus.sub   = s;
        bus.a     = av;
        bus.b     = bv;
        bus.c_in  = cin;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.sub   = 1'($urandom);
        bus.c_in  = 1'($urandom);
        n = 0;
        while (bus.busy && n < 40) begin
            if (n == 8) begin
                chk("run_hold_sum", 64'(bus.sum), 64'(exp_sum));
                chk("run_no_done",  64'(bus.done), 64'd0);
            end
            if (n == at && kind == 1) begin
                bus.start = 1'b1;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
            end
            if (n == at && kind == 2) begin
                bus.abort = 1'b1;
                bus.start = 1'b1;
            end
            n++;
            step();
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
        if (kind == 2) begin
            chk("abort_cycles", 64'(n), 64'(at + 1));
            chk("abort_busy",   64'(bus.busy), 64'd0);
            dones = 0;
            for (int i = 0; i < 4; i++) begin
                if (bus.done) dones++;
                step();
            end
            chk("abort_no_done", 64'(dones), 64'd0);
            check_outputs("abort_hold");
        end else begin
            chk("busy_len", 64'(n), 64'd16);
            chk("done_seen", 64'(bus.done), 64'd1);
            exp_sum   = ms;
            exp_c_out = mc;
            exp_ovf   = mo;
            check_outputs("result");
        end
    endtask

    task automatic to_idle();
        step();
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_done", 64'(bus.done), 64'd0);
    endtask

    initial begin
        int  kind;
        int  at;
        bit  at_done;
        logic s;
        logic [W-1:0] av;
        logic [W-1:0] bv;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c_in  = 1'b0;
        exp_sum   = '0;
        exp_c_out = 1'b0;
        exp_ovf   = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        check_outputs("rst");
        step();
        step();
        @(negedge clk) rst_n = 1'b1;

        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 0, 0);
        chk("d33_sum", 64'(bus.sum), 64'h8000);
        chk("d33_c_out", 64'(bus.c_out), 64'd0);
        chk("d33_ovf", 64'(bus.ovf), 64'd1);
        to_idle();

        run_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, 0, 0);
        chk("d34_sum", 64'(bus.sum), 64'h0000);
        chk("d34_c_out", 64'(bus.c_out), 64'd1);
        chk("d34_ovf", 64'(bus.ovf), 64'd0);
        to_idle();

        run_op(1'b1, 16'h0005, 16'h0007, 1'b1, 0, 0);
        chk("d35a_sum", 64'(bus.sum), 64'hFFFE);
        chk("d35a_c_out", 64'(bus.c_out), 64'd0);
        chk("d35a_ovf", 64'(bus.ovf), 64'd0);
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 0, 0);
        chk("d35b_sum", 64'(bus.sum), 64'h7FFF);
        chk("d35b_c_out", 64'(bus.c_out), 64'd1);
        chk("d35b_ovf", 64'(bus.ovf), 64'd1);
        to_idle();

        run_op(1'b0, 16'h1111, 16'h2222, 1'b0, 1, 4);
        chk("d36_sum", 64'(bus.sum), 64'h3333);
        to_idle();

        run_op(1'b0, 16'hAAAA, 16'h1111, 1'b0, 2, 7);
        chk("d37_sum", 64'(bus.sum), 64'h3333);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("idle_abort_busy", 64'(bus.busy), 64'd0);
        chk("idle_abort_done", 64'(bus.done), 64'd0);
        chk("idle_abort_sum", 64'(bus.sum), 64'h3333);

        bus.sub   = 1'b0;
        bus.a     = 16'hF0F0;
        bus.b     = 16'h0F0F;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        exp_sum   = '0;
        exp_c_out = 1'b0;
        exp_ovf   = 1'b0;
        chk("rst_run_busy", 64'(bus.busy), 64'd0);
        chk("rst_run_done", 64'(bus.done), 64'd0);
        check_outputs("rst_run");
        @(negedge clk) rst_n = 1'b1;
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 0, 0);
        chk("d38_sum", 64'(bus.sum), 64'h5555);
        to_idle();

        at_done = 1'b0;
        for (int it = 0; it < 40; it++) begin
            kind = ($urandom_range(0, 5) == 0) ? 2 : (($urandom_range(0, 5) == 0) ? 1 : 0);
            at   = int'($urandom_range(0, 15));
            s    = 1'($urandom);
            av   = W'($urandom);
            bv   = W'($urandom);
            if (it % 8 == 0) bv = av;
            run_op(s, av, bv, 1'($urandom), kind, at);
            at_done = 1'b0;
            if (kind != 2) begin
                if ($urandom_range(0, 1) == 0) begin
                    to_idle();
                end else begin
                    at_done = 1'b1;
                end
            end
        end
        if (at_done) to_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous cancel of an operation in progress.
REQ-006 The block SHALL have port sub, input, 1 bit: 0 selects a+b+c_in, 1 selects a-b.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands, two's complement.
REQ-008 The block SHALL have port c_in, input, 1 bit: carry-in, used for add only.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: last completed result.
REQ-012 The block SHALL have ports c_out and ovf, output, 1 bit each: carry-out and signed overflow of the last completed result.

Function
REQ-013 The block SHALL compute the result bit-serially, LSB first, through exactly one 1-bit full-adder cell, with one bit per clock and a 1-bit carry register.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL accept the operation: latch a, b and sub into internal shift registers; load the carry register; clear the bit counter; go to RUN.
REQ-016 On accept, the carry register SHALL load c_in when sub=0, or 1 when sub=1; when sub=1, c_in is ignored and b is bit-inverted on entry to the adder.
REQ-017 In RUN, each edge SHALL shift one adder sum bit into the internal result register, update the carry register and increment the counter.
REQ-018 The edge that processes bit WIDTH-1 SHALL copy the internal result to sum, set c_out to the final carry and set ovf to (carry into MSB) XOR (carry out of MSB), then go to DONE.
REQ-019 Latency: with accept at edge E0, bit steps occur at edges E1..E_WIDTH, done=1 in the cycle following E_WIDTH, and the block returns to IDLE at E_WIDTH+1 unless start=1.
REQ-020 When sub=1, c_out SHALL equal NOT borrow, so c_out=1 means a>=b unsigned.
REQ-021 busy SHALL be 1 exactly while the state is RUN; done SHALL be 1 exactly while the state is DONE.
REQ-022 start SHALL be ignored while in RUN, with no change to the operands in flight.
REQ-023 An accept in DONE SHALL give back-to-back operation with no idle cycle between.
REQ-024 abort=1 in RUN SHALL return the FSM to IDLE at that edge, leave sum, c_out and ovf unchanged, and produce no done pulse.
REQ-025 abort SHALL take priority over the bit step at the same edge.
REQ-026 abort SHALL be ignored outside RUN.
REQ-027 If abort=1 and start=1 in RUN on the same edge, the block SHALL abort and SHALL NOT accept start.
REQ-028 sum, c_out and ovf SHALL hold stable from one completion until the next completion, including throughout RUN.
REQ-029 When sub=1, all arithmetic SHALL be modulo 2^WIDTH; the carry SHALL NOT propagate beyond the MSB into the next operation.

Reset
REQ-030 When rst_n=0, the block SHALL immediately, independent of clk, force state=IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, and clear the counter, carry and shift registers.
REQ-031 Reset asserted during RUN SHALL discard the operation with no done pulse.
REQ-032 After rst_n deasserts, the first accept SHALL be possible at the first rising edge with rst_n=1.

Verification (WIDTH=16)
REQ-033 The bench SHALL cover: a=0x7FFF, b=0x0001, c_in=0, sub=0 -> at cycle 17 after accept, done=1, sum=0x8000, c_out=0, ovf=1; busy=1 for exactly 16 cycles.
REQ-034 The bench SHALL cover: a=0xFFFF, b=0x0000, c_in=1, sub=0 -> sum=0x0000, c_out=1, ovf=0.
REQ-035 The bench SHALL cover: sub=1 with a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0, ovf=0; then back-to-back start in DONE with sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1, and 16 cycles between the two done pulses.
REQ-036 The bench SHALL cover: start pulsed in cycle 5 of RUN with different operands -> ignored, and the first result completes unchanged.
REQ-037 The bench SHALL cover: abort at cycle 8 of RUN -> busy=0 next cycle, no done, and sum still holds the previous result; abort in IDLE -> no effect.
REQ-038 The bench SHALL cover: rst_n low mid-RUN, asynchronous to clk -> all outputs 0 immediately; then a fresh add of 0x1234+0x4321 -> 0x5555.
